// File: rtl/video_pkg.sv
// Shared video types: test-pattern select, writer FSM states and bar colours.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_CHECKER  = 2'd0,
        PAT_GRADIENT = 2'd1,
        PAT_BARS     = 2'd2,
        PAT_WHITE    = 2'd3
    } pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    // Colour of vertical bar 0..7, left to right.
    function automatic logic [23:0] bar_color(input logic [2:0] bar);
        case (bar)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/mire_color.sv
// Combinational pixel colour generator: pattern select and (x, y) -> 24-bit RGB.
module mire_color
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic [1:0]    pattern,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [23:0]   rgb
);

    localparam int BAR_W = (HDISP >= 8) ? HDISP / 8 : 1;

    logic [31:0] bar_num;

    // Select the colour of the current pixel from the latched pattern.
    always_comb begin
        bar_num = 32'(x) / BAR_W;
        rgb     = COL_BLACK;
        case (pattern_t'(pattern))
            PAT_CHECKER:  rgb = ((((32'(x) ^ 32'(y)) >> 4) & 32'd1) != 32'd0) ? COL_WHITE : COL_BLACK;
            PAT_GRADIENT: rgb = {3{8'(x)}};
            PAT_BARS:     rgb = bar_color((bar_num > 32'd7) ? 3'd7 : 3'(bar_num));
            PAT_WHITE:    rgb = COL_WHITE;
            default:      rgb = COL_WHITE;
        endcase
    end

endmodule

// File: rtl/mire_writer.sv
// Test-pattern frame writer: streams one frame of pixels to a Wishbone slave,
// dropping the bus for one cycle every BURST acks and at frame end.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | bus released, waiting for start or continuous
// ST_WRITE   | cyc/stb asserted, current pixel held until ack
// ST_RELEASE | one-cycle bus release after a burst or between frames
module mire_writer
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  pattern,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    input  logic        wshb_ack,
    output logic        busy,
    output logic        frame_done
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int IW = $clog2(HDISP * VDISP);
    localparam int BW = $clog2(BURST + 1);

    localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
    localparam logic [IW-1:0] I_LAST = IW'(HDISP * VDISP - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

    state_t          state_q, state_d;
    pattern_t        pat_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [IW-1:0]   idx_q;
    logic [BW-1:0]   burst_q;
    logic [23:0]     rgb;
    logic            last_px;
    logic            burst_end;

    assign last_px   = (idx_q == I_LAST);
    assign burst_end = (burst_q == B_LAST);

    // State register.
    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Next state and bus/status outputs; frame-end takes priority over burst-end.
    always_comb begin
        state_d    = state_q;
        wshb_cyc   = 1'b0;
        wshb_stb   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start || continuous) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wshb_cyc = 1'b1;
                wshb_stb = 1'b1;
                if (wshb_ack) begin
                    if (last_px) begin
                        frame_done = wshb_rst_n;
                        state_d    = continuous ? ST_RELEASE : ST_IDLE;
                    end else if (burst_end) begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: state_d = ST_WRITE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pixel position, burst counter and pattern latch; index 0 in RELEASE means a frame restart.
    always_ff @(posedge wshb_clk) begin
        if (!wshb_rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            burst_q <= '0;
            pat_q   <= PAT_CHECKER;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start || continuous) pat_q <= pattern_t'(pattern);
                end
                ST_WRITE: begin
                    if (wshb_ack) begin
                        if (last_px) begin
                            x_q     <= '0;
                            y_q     <= '0;
                            idx_q   <= '0;
                            burst_q <= '0;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            burst_q <= burst_end ? '0 : burst_q + BW'(1);
                            if (x_q == X_LAST) begin
                                x_q <= '0;
                                y_q <= y_q + YW'(1);
                            end else begin
                                x_q <= x_q + XW'(1);
                            end
                        end
                    end
                end
                ST_RELEASE: begin
                    if (idx_q == '0) pat_q <= pattern_t'(pattern);
                end
                default: ;
            endcase
        end
    end

    mire_color #(
        .HDISP (HDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_color (
        .pattern (pat_q),
        .x       (x_q),
        .y       (y_q),
        .rgb     (rgb)
    );

    assign wshb_we     = 1'b1;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = 3'd0;
    assign wshb_bte    = 2'd0;
    assign wshb_adr    = 32'(idx_q) << 2;
    assign wshb_dat_ms = {8'h00, rgb};

endmodule

// File: tb/tb_mire_writer.sv
// Scoreboard bench for mire_writer on a 32x4 frame with 8-ack bursts.
module tb_mire_writer;

    localparam int H    = 32;
    localparam int V    = 4;
    localparam int B    = 8;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic        ack = 1'b0;
    logic        cyc, stb, we, busy, frame_done;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] adr, dat;

    always #5 clk = ~clk;

    mire_writer #(.HDISP(H), .VDISP(V), .BURST(B)) dut (
        .wshb_clk    (clk),
        .wshb_rst_n  (rst_n),
        .start       (start),
        .continuous  (continuous),
        .pattern     (pattern),
        .wshb_cyc    (cyc),
        .wshb_stb    (stb),
        .wshb_we     (we),
        .wshb_sel    (sel),
        .wshb_cti    (cti),
        .wshb_bte    (bte),
        .wshb_adr    (adr),
        .wshb_dat_ms (dat),
        .wshb_ack    (ack),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img [NPIX];
    int          writes = 0, fd_cnt = 0, rel_cnt = 0, long_rel = 0, busy_cyc = 0, acks_issued = 0;
    int          mode = 0;   // 0: ack one cycle after stb, 1: random 0-5 waits, 2: ack every cycle

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference pixel word for pattern pat at linear index idx.
    function automatic logic [31:0] gold(input int pat, input int idx);
        int x;
        int y;
        logic [23:0] c;
        x = idx % H;
        y = idx / H;
        case (pat)
            0: c = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            1: c = {x[7:0], x[7:0], x[7:0]};
            2: begin
                case (x / (H / 8))
                    0:       c = 24'hFFFFFF;
                    1:       c = 24'hFFFF00;
                    2:       c = 24'h00FFFF;
                    3:       c = 24'h00FF00;
                    4:       c = 24'hFF00FF;
                    5:       c = 24'hFF0000;
                    6:       c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            default: c = 24'hFFFFFF;
        endcase
        return {8'h00, c};
    endfunction

    task automatic push_frame(input int pat, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({32'(i * 4), gold(pat, i)});
    endtask

    // Wishbone slave: drives ack after a per-request number of wait cycles.
    initial begin
        int wcnt;
        bit pending;
        wcnt = 0;
        pending = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!(cyc && stb)) begin
                ack = 1'b0;
                pending = 0;
            end else begin
                if (!pending) begin
                    pending = 1;
                    case (mode)
                        0:       wcnt = 1;
                        1:       wcnt = $urandom_range(0, 5);
                        default: wcnt = 0;
                    endcase
                end
                if (wcnt == 0) begin
                    ack = 1'b1;
                    pending = 0;
                    acks_issued++;
                end else begin
                    ack = 1'b0;
                    wcnt--;
                end
            end
        end
    end

    // Monitor: scoreboard compare on each accepted write, hold and release bookkeeping.
    initial begin
        logic [63:0] e;
        bit          prev_rel;
        bit          prev_hold;
        logic [31:0] prev_adr, prev_dat;
        prev_rel = 0;
        prev_hold = 0;
        prev_adr = '0;
        prev_dat = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy) busy_cyc++;
                if (busy && !cyc) begin
                    rel_cnt++;
                    if (prev_rel) long_rel++;
                    prev_rel = 1;
                end else begin
                    prev_rel = 0;
                end
                if (frame_done) fd_cnt++;
                if (cyc && stb && prev_hold) begin
                    chk("hold_adr", adr, prev_adr);
                    chk("hold_dat", dat, prev_dat);
                end
                prev_hold = cyc && stb && !ack;
                prev_adr = adr;
                prev_dat = dat;
                if (cyc && stb && ack) begin
                    writes++;
                    if (adr < NPIX * 4) img[adr >> 2] = dat;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: write at adr 0x%0h data 0x%0h, expected none", adr, dat);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_adr", adr, e[63:32]);
                        chk("sb_dat", dat, e[31:0]);
                    end
                end
            end else begin
                prev_hold = 0;
                prev_rel = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string name);
        int n;
        n = 0;
        while (fd_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (fd_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: frame_done count %0d, expected %0d", name, fd_cnt, target);
        end
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        n = 0;
        while (writes < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (writes < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: writes %0d, expected %0d", name, writes, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0, r0, l0, b0, a0, n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_we", we, 1);
        chk("rst_sel", sel, 4'hF);
        chk("rst_cti", cti, 0);
        chk("rst_bte", bte, 0);
        chk("rst_adr", adr, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single checker frame, one-cycle ack latency
        mode = 0; pattern = 2'd0;
        w0 = writes; f0 = fd_cnt; r0 = rel_cnt; l0 = long_rel;
        push_frame(0, NPIX);
        pulse_start();
        wait_fd(f0 + 1, "a_frame");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("a_writes", writes - w0, NPIX);
        chk("a_frame_done", fd_cnt - f0, 1);
        chk("a_releases", rel_cnt - r0, 15);
        chk("a_long_release", long_rel - l0, 0);
        chk("a_busy_idle", busy, 0);
        chk("a_cyc_idle", cyc, 0);
        chk("a_queue_empty", exp_q.size(), 0);
        chk("a_px_16_0", img[16], 32'h00FFFFFF);
        chk("a_px_0_0", img[0], 32'h00000000);
        chk("a_px_15_0", img[15], 32'h00000000);
        chk("a_px_16_1", img[48], 32'h00FFFFFF);
        chk("a_px_31_3", img[127], 32'h00FFFFFF);

        // Bars frame with random wait states
        mode = 1; pattern = 2'd2;
        w0 = writes;
        push_frame(2, NPIX);
        pulse_start();
        wait_fd(fd_cnt + 1, "b_frame");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("b_writes", writes - w0, NPIX);
        chk("b_queue_empty", exp_q.size(), 0);
        chk("b_px_yellow", img[4], 32'h00FFFF00);
        chk("b_px_cyan", img[8], 32'h0000FFFF);
        chk("b_px_magenta", img[16], 32'h00FF00FF);
        chk("b_px_red", img[20], 32'h00FF0000);
        chk("b_px_blue", img[56], 32'h000000FF);
        chk("b_px_black", img[31], 32'h00000000);

        // Continuous: gradient then white after a mid-frame pattern change
        mode = 0;
        w0 = writes; f0 = fd_cnt; r0 = rel_cnt; l0 = long_rel;
        push_frame(1, NPIX);
        push_frame(3, NPIX);
        @(posedge clk); #2 pattern = 2'd1; continuous = 1'b1;
        wait_writes(w0 + 64, "c_mid");
        @(posedge clk); #2 pattern = 2'd3;
        wait_fd(f0 + 1, "c_frame1");
        @(posedge clk); #2 continuous = 1'b0;
        wait_fd(f0 + 2, "c_frame2");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("c_writes", writes - w0, 2 * NPIX);
        chk("c_frame_done", fd_cnt - f0, 2);
        chk("c_releases", rel_cnt - r0, 31);
        chk("c_long_release", long_rel - l0, 0);
        chk("c_busy_idle", busy, 0);
        chk("c_queue_empty", exp_q.size(), 0);
        chk("c_px_5_0", img[5], 32'h00FFFFFF);

        // Back-to-back acks, start re-pulsed mid-frame
        mode = 2; pattern = 2'd3;
        w0 = writes; f0 = fd_cnt; b0 = busy_cyc;
        push_frame(3, NPIX);
        pulse_start();
        wait_writes(w0 + 40, "d_mid");
        pulse_start();
        wait_fd(f0 + 1, "d_frame");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("d_writes", writes - w0, NPIX);
        chk("d_busy_cycles", busy_cyc - b0, NPIX + 15);
        chk("d_frame_done", fd_cnt - f0, 1);
        chk("d_busy_idle", busy, 0);
        chk("d_queue_empty", exp_q.size(), 0);

        // Reset at the 50th ack, then a clean restart from index 0
        mode = 0; pattern = 2'd2;
        w0 = writes;
        push_frame(2, 49);
        a0 = acks_issued;
        pulse_start();
        n = 0;
        forever begin
            @(posedge clk); #2;
            n++;
            if ((ack && (acks_issued - a0) == 50) || n >= 1000) break;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL e_ack50_timeout: acks %0d, expected 50", acks_issued - a0);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("e_cyc_at_reset", cyc, 0);
        chk("e_stb_at_reset", stb, 0);
        chk("e_busy_at_reset", busy, 0);
        chk("e_writes_before_reset", writes - w0, 49);
        chk("e_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; pattern = 2'd0;
        w0 = writes;
        push_frame(0, NPIX);
        pulse_start();
        wait_fd(fd_cnt + 1, "e_frame");
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("e_restart_writes", writes - w0, NPIX);
        chk("e_restart_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mire_writer.md
MIRE_WRITER -- requirements
Module: mire_writer

Interface
REQ-001 Parameter HDISP, default 800, frame width in pixels.
REQ-002 Parameter VDISP, default 480, frame height in lines.
REQ-003 Parameter BURST, default 64, number of acknowledged writes before a mandatory bus release.
REQ-004 wshb_clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 wshb_rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  single-cycle pulse that requests one frame write while the block is idle.
REQ-007 continuous  in  1  when 1, the block restarts a new frame automatically after each frame.
REQ-008 pattern  in  2  pattern select: 0 = checker, 1 = horizontal gradient, 2 = vertical bars, 3 = solid white.
REQ-009 wshb_cyc, wshb_stb  out  1 each  Wishbone classic cycle and strobe.
REQ-010 wshb_we  out  1  constant 1.
REQ-011 wshb_sel  out  4  constant 4'hF.
REQ-012 wshb_cti  out  3  constant 0.
REQ-013 wshb_bte  out  2  constant 0.
REQ-014 wshb_adr  out  32  byte address = pixel index << 2.
REQ-015 wshb_dat_ms  out  32  pixel word: {8'h00, R, G, B}.
REQ-016 wshb_ack  in  1  slave acknowledge.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 frame_done  out  1  one-cycle pulse on acceptance of the last pixel of a frame.

Function
REQ-019 The FSM SHALL have the states IDLE, WRITE and RELEASE.
REQ-020 IDLE: cyc = stb = 0; go to WRITE on (start or continuous); pattern is latched at this transition.
REQ-021 WRITE: cyc = stb = 1; adr and dat_ms hold stable until ack; on ack, pixel index +1, x +1, x wraps at HDISP-1 to 0 with y +1.
REQ-022 The burst counter SHALL count acks in WRITE; at the BURST-th ack, go to RELEASE and clear the counter.
REQ-023 RELEASE SHALL last exactly one cycle with cyc = stb = 0, then return to WRITE.
REQ-024 On the ack at pixel index HDISP*VDISP-1: pulse frame_done, reset x, y and the index to 0, clear the burst counter, go to RELEASE if continuous = 1, else to IDLE.
REQ-025 When the last pixel and the BURST-th ack coincide, REQ-024 SHALL take priority and give a single release.
REQ-026 In continuous mode, pattern SHALL be re-latched when the restart leaves RELEASE after frame_done; a pattern change mid-frame is ignored.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 Pixel colour from latched pattern (x, y), combinational from the registered counters:
 - checker: white when x[4] XOR y[4], else black;
 - gradient: R = G = B = x[7:0];
 - bars: 8 bars of width HDISP/8 with colours white, yellow, cyan, green, magenta, red, blue, black;
 - solid white: 24'hFFFFFF.
REQ-029 Widths: x $clog2(HDISP), y $clog2(VDISP), index $clog2(HDISP*VDISP), burst counter $clog2(BURST+1).
REQ-030 Throughput: one pixel per ack; back-to-back acks SHALL be accepted on consecutive cycles.

Reset
REQ-031 While wshb_rst_n = 0 at a clock edge: state IDLE, x = y = index = burst counter = 0, latched pattern = 0, cyc = stb = busy = frame_done = 0.
REQ-032 Reset asserted mid-frame SHALL drop cyc/stb at that edge; the next frame restarts at index 0.

Structure
REQ-033 Shared package video_pkg SHALL hold the pattern enum, the colour constants for the 8 bars and the state typedef.
REQ-034 One sub-module, mire_color (pattern, x, y -> 24-bit RGB), purely combinational; the FSM and counters stay in mire_writer.

Verification (bench HDISP=32, VDISP=4, BURST=8, slave acks 1 cycle after stb unless stated)
REQ-035 start pulse, continuous=0, pattern=0 -> exactly 128 writes at addresses 0x000..0x1FC, frame_done once, then IDLE with busy=0.
REQ-036 Same run -> cyc low for exactly 1 cycle after every 8th ack: 15 releases plus 1 at the end of the frame; pixel (16,0) = 0x00FFFFFF and pixel (16,16 mod 4) follows the checker rule.
REQ-037 Slave inserts random 0-5 wait states -> adr/dat_ms stable while stb & !ack; the written image equals the golden model.
REQ-038 continuous=1, pattern 1 then changed to 3 mid-frame -> frame 1 is all gradient, frame 2 is all 0x00FFFFFF; one RELEASE between frames.
REQ-039 Reset asserted at the 50th ack -> cyc=0 at that edge; after start the first address is 0x000.
REQ-040 start pulsed during WRITE -> no effect; total writes still 128.
